// File: rtl/mem_req_queue_pkg.sv
// mem_req_queue_pkg: shared length encodings, idle port value, queue entry layout and FSM states.
package mem_req_queue_pkg;
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;
    localparam int LEN_UNSIGNED_BIT = 2;
    localparam logic [2:0] LEN_IDLE = 3'b111;
    // Tag field is sized for the widest supported ROB tag; the top narrows it back to TAG_W.
    localparam int TAG_MAX = 8;

    typedef struct packed {
        logic               wr;
        logic [2:0]         len;
        logic [31:0]        addr;
        logic [31:0]        value;
        logic [TAG_MAX-1:0] tag;
        logic               killed;
    } entry_t;

    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: circular request store with pointers, count, full flag and a broadside kill of queued loads.
module mem_req_fifo
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH_LOG = 3
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   kill,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    entry_t mem [DEPTH];
    logic [DEPTH_LOG-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_LOG:0] count;

    assign head  = mem[rd_ptr];
    assign full  = count[DEPTH_LOG];
    assign empty = count == '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_LOG+1)'(push) - (DEPTH_LOG+1)'(pop);
        end
    end

    // A store pushed alongside a kill lands after the sweep, so it is never marked.
    always_ff @(posedge clk_in) begin
        if (kill)
            for (int i = 0; i < DEPTH; i++)
                if (!mem[i].wr) mem[i].killed <= 1'b1;
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order load/store issue queue with rob_clear load squashing.
// Define MEM_REQ_QUEUE_STATS_EN to build the stat_* counters; otherwise they read 0.
module mem_req_queue
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH_LOG = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             enq_valid,
    input  logic             enq_wr,
    input  logic [2:0]       enq_len,
    input  logic [31:0]      enq_addr,
    input  logic [31:0]      enq_value,
    input  logic [TAG_W-1:0] enq_tag,
    output logic             enq_full,
    output logic             data_valid,
    output logic             data_wr,
    output logic [2:0]       data_len,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_value,
    input  logic             data_ready,
    input  logic [31:0]      data_result,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      res_value,
    output logic [31:0]      stat_loads,
    output logic [31:0]      stat_stores,
    output logic [31:0]      stat_killed,
    output logic [31:0]      stat_wait
);
    state_t state, state_n;
    entry_t head, enq_entry;
    logic full, empty, accept, push, head_dead, skip, issue, done;

    assign enq_full  = full;
    assign accept    = rdy_in && enq_valid && !full;
    assign push      = accept && !(rob_clear && !enq_wr);
    // A load at the head is already dead if the flush lands on this very edge.
    assign head_dead = head.killed || (rob_clear && !head.wr);
    assign enq_entry = '{wr: enq_wr, len: enq_len, addr: enq_addr, value: enq_value,
                         tag: TAG_MAX'(enq_tag), killed: 1'b0};

    mem_req_fifo #(.DEPTH_LOG(DEPTH_LOG)) fifo (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .push(push),
        .push_data(enq_entry),
        .pop(skip || done),
        .kill(rdy_in && rob_clear),
        .head(head),
        .full(full),
        .empty(empty)
    );

    always_comb begin
        skip    = rdy_in && state == IDLE && !empty && head_dead;
        issue   = rdy_in && state == IDLE && !empty && !head_dead;
        done    = rdy_in && state == BUSY && data_ready;
        state_n = issue ? BUSY : done ? IDLE : state;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_valid <= 1'b0;
            data_wr    <= 1'b0;
            data_len   <= LEN_IDLE;
            data_addr  <= '0;
            data_value <= '0;
            res_valid  <= 1'b0;
            res_tag    <= '0;
            res_value  <= '0;
        end else if (rdy_in) begin
            res_valid <= done && !head.wr && !head_dead;
            if (issue) begin
                data_valid <= 1'b1;
                data_wr    <= head.wr;
                data_len   <= head.len;
                data_addr  <= head.addr;
                data_value <= head.value;
            end else if (done) begin
                data_valid <= 1'b0;
                data_wr    <= 1'b0;
                data_len   <= LEN_IDLE;
                data_addr  <= '0;
                data_value <= '0;
            end
            if (done && !head.wr) begin
                res_tag   <= TAG_W'(head.tag);
                res_value <= data_result;
            end
        end
    end

`ifdef MEM_REQ_QUEUE_STATS_EN
    logic [31:0] n_loads, n_stores, n_killed, n_wait;
    logic drop;

    assign drop = accept && rob_clear && !enq_wr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            n_loads  <= '0;
            n_stores <= '0;
            n_killed <= '0;
            n_wait   <= '0;
        end else if (rdy_in) begin
            n_loads  <= n_loads + 32'(done && !head.wr && !head_dead);
            n_stores <= n_stores + 32'(done && head.wr);
            n_killed <= n_killed + 32'(skip) + 32'(done && !head.wr && head_dead) + 32'(drop);
            n_wait   <= n_wait + 32'(state == BUSY);
        end
    end

    assign stat_loads  = n_loads;
    assign stat_stores = n_stores;
    assign stat_killed = n_killed;
    assign stat_wait   = n_wait;
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_killed = '0;
    assign stat_wait   = '0;
`endif
endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: directed scenarios plus randomized traffic against a queue-level reference model.
module tb_mem_req_queue;
    import mem_req_queue_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear, enq_valid, enq_wr, data_ready;
    logic [2:0]  enq_len;
    logic [31:0] enq_addr, enq_value, data_result;
    logic [3:0]  enq_tag;
    logic        enq_full, data_valid, data_wr, res_valid;
    logic [2:0]  data_len;
    logic [31:0] data_addr, data_value, res_value;
    logic [3:0]  res_tag;
    logic [31:0] stat_loads, stat_stores, stat_killed, stat_wait;

    mem_req_queue #(.DEPTH_LOG(3), .TAG_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .enq_valid(enq_valid), .enq_wr(enq_wr), .enq_len(enq_len), .enq_addr(enq_addr),
        .enq_value(enq_value), .enq_tag(enq_tag), .enq_full(enq_full),
        .data_valid(data_valid), .data_wr(data_wr), .data_len(data_len),
        .data_addr(data_addr), .data_value(data_value), .data_ready(data_ready),
        .data_result(data_result), .res_valid(res_valid), .res_tag(res_tag),
        .res_value(res_value), .stat_loads(stat_loads), .stat_stores(stat_stores),
        .stat_killed(stat_killed), .stat_wait(stat_wait)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        wr;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] value;
        logic [3:0]  tag;
    } op_t;

    // Model: live accepted ops awaiting issue, plus the one on the data port.
    op_t pend[$];
    op_t cur;
    logic [31:0] req_addrs[$];
    bit busy, cur_dead, lingering, exp_rv;
    logic [3:0] exp_tag;
    logic [31:0] exp_val;
    int errors, checks, n_res;
    int m_loads, m_stores, m_killed, m_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_req(input string p);
        chk({p, "_wr"}, data_wr, cur.wr);
        chk({p, "_len"}, data_len, cur.len);
        chk({p, "_addr"}, data_addr, cur.addr);
        chk({p, "_value"}, data_value, cur.value);
    endtask

    task automatic set_enq(input bit v, input bit wr, input logic [2:0] len,
                           input logic [31:0] addr, input logic [31:0] value, input logic [3:0] tag);
        enq_valid = v; enq_wr = wr; enq_len = len; enq_addr = addr; enq_value = value; enq_tag = tag;
    endtask

    task automatic enq_rand(input bit v);
        set_enq(v, 1'($urandom), {1'($urandom), $urandom_range(0, 2) == 0 ? LEN_B :
                $urandom_range(0, 1) == 0 ? LEN_H : LEN_W}, $urandom, $urandom, 4'($urandom));
    endtask

    task automatic clear_model();
        pend.delete();
        busy = 0; cur_dead = 0; lingering = 0; exp_rv = 0;
        m_loads = 0; m_stores = 0; m_killed = 0; m_wait = 0;
    endtask

    task automatic tick();
        bit done_now, rdy_e;
        int cnt;
        op_t keep[$];
        done_now = 0;
        rdy_e = rdy_in;
        cnt = pend.size() + int'(busy);
        if (rdy_in) begin
            if (busy) m_wait++;
            exp_rv = 1'b0;
            if (busy && data_ready) begin
                done_now = 1'b1;
                busy = 1'b0;
                if (cur.wr) m_stores++;
                else if (cur_dead || rob_clear) m_killed++;
                else begin
                    m_loads++;
                    exp_rv = 1'b1; exp_tag = cur.tag; exp_val = data_result;
                end
            end
            if (rob_clear) begin
                if (busy && !cur.wr) cur_dead = 1'b1;
                foreach (pend[i])
                    if (pend[i].wr) keep.push_back(pend[i]);
                    else begin m_killed++; lingering = 1'b1; end
                pend = keep;
            end
            if (enq_valid && cnt < 8) begin
                if (rob_clear && !enq_wr) m_killed++;
                else pend.push_back('{enq_wr, enq_len, enq_addr, enq_value, enq_tag});
            end
        end
        @(posedge clk_in);
        #1;
        if (done_now) chk("dv_low_after_ready", data_valid, 0);
        if (busy) begin
            chk("dv_hold", data_valid, 1);
            cmp_req("hold");
        end else if (data_valid) begin
            chk("req_expected", pend.size() > 0, 1);
            if (pend.size() > 0) begin
                cur = pend.pop_front();
                cur_dead = 0;
                busy = 1;
                req_addrs.push_back(cur.addr);
                cmp_req("issue");
            end
        end else begin
            chk("idle_ctl", {data_wr, data_len}, 4'b0111);
            chk("idle_data", data_addr | data_value, 0);
        end
        chk("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
            chk("res_tag", res_tag, exp_tag);
            chk("res_value", res_value, exp_val);
        end
        if (rdy_e && res_valid) n_res++;
        if (!lingering) chk("enq_full", enq_full, (pend.size() + int'(busy)) == 8);
    endtask

    task automatic check_stats();
`ifdef MEM_REQ_QUEUE_STATS_EN
        chk("stat_loads", stat_loads, m_loads);
        chk("stat_stores", stat_stores, m_stores);
        chk("stat_killed", stat_killed, m_killed);
        chk("stat_wait", stat_wait, m_wait);
`else
        chk("stat_tied", stat_loads | stat_stores | stat_killed | stat_wait, 0);
`endif
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        enq_valid = 0; rob_clear = 0;
        while ((pend.size() > 0 || busy) && guard < 400) begin
            rdy_in = 1; data_ready = 1'($urandom); data_result = $urandom;
            tick();
            guard++;
        end
        chk("drain_bound", guard < 400, 1);
        data_ready = 0;
        repeat (10) tick();
        lingering = 0;
        chk("drained_not_full", enq_full, 0);
        check_stats();
    endtask

    task automatic wait_busy();
        for (int g = 0; g < 20 && !busy; g++) tick();
        chk("wait_busy", busy, 1);
    endtask

    task automatic do_reset();
        set_enq(0, 0, 0, 0, 0, 0);
        rob_clear = 0; data_ready = 0; rdy_in = 1;
        @(posedge clk_in);
        #3;
        rst_in = 1;
        #1;
        chk("rst_dv", data_valid, 0);
        chk("rst_len", data_len, 3'b111);
        chk("rst_res", res_valid, 0);
        @(posedge clk_in);
        #1;
        rst_in = 0;
        clear_model();
    endtask

    initial begin
        int base_req, base_res;
        errors = 0; checks = 0; n_res = 0;
        clear_model();
        rst_in = 1; rdy_in = 1; rob_clear = 0; data_ready = 0; data_result = 0;
        set_enq(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_dv", data_valid, 0);
        chk("reset_len", data_len, 3'b111);
        chk("reset_port", {data_wr, data_addr | data_value}, 0);
        chk("reset_res", {res_valid, res_tag}, 0);
        chk("reset_full", enq_full, 0);
        check_stats();
        rst_in = 0;

        // Single word load: latency of issue and of result.
        set_enq(1, 0, {1'b0, LEN_W}, 32'h100, 0, 4'd3);
        tick();
        chk("t1_c1_idle", data_valid, 0);
        set_enq(0, 0, 0, 0, 0, 0);
        tick();
        chk("t1_c2_valid", data_valid, 1);
        chk("t1_len", data_len, 3'b010);
        repeat (3) tick();
        data_ready = 1; data_result = 32'hDEADBEEF;
        tick();
        data_ready = 0;
        chk("t1_res", res_valid, 1);
        chk("t1_tag", res_tag, 4'd3);
        chk("t1_val", res_value, 32'hDEADBEEF);
        chk("t1_dv_low", data_valid, 0);
        tick();
        chk("t1_pulse_end", res_valid, 0);

        // Fill with memory stalled; ninth enqueue must vanish.
        base_req = req_addrs.size();
        for (int i = 0; i < 9; i++) begin
            enq_rand(1);
            tick();
            if (i == 7) chk("full_set", enq_full, 1);
        end
        chk("full_hold", enq_full, 1);
        enq_valid = 0; data_ready = 1; data_result = $urandom;
        tick();
        data_ready = 0;
        chk("full_clear", enq_full, 0);
        drain();
        chk("full_req_count", req_addrs.size() - base_req, 8);

        // Mid-transaction reset.
        set_enq(1, 1, {1'b0, LEN_W}, 32'h200, 32'h55, 0);
        tick();
        enq_valid = 0;
        wait_busy();
        do_reset();
        repeat (3) tick();
        chk("post_rst_idle", data_valid, 0);
        chk("post_rst_full", enq_full, 0);

        // Store A, load B, store C, load D; flush while A is in flight.
        base_req = req_addrs.size();
        base_res = n_res;
        set_enq(1, 1, {1'b0, LEN_W}, 32'hA0, 32'h1, 0);  tick();
        set_enq(1, 0, {1'b0, LEN_W}, 32'hB0, 0, 4'd1);   tick();
        set_enq(1, 1, {1'b0, LEN_H}, 32'hC0, 32'h2, 0);  tick();
        set_enq(1, 0, {1'b1, LEN_B}, 32'hD0, 0, 4'd2);   tick();
        enq_valid = 0;
        wait_busy();
        rob_clear = 1;
        tick();
        rob_clear = 0;
        drain();
        chk("flush_req_count", req_addrs.size() - base_req, 2);
        if (req_addrs.size() - base_req == 2) begin
            chk("flush_req_a", req_addrs[base_req], 32'hA0);
            chk("flush_req_c", req_addrs[base_req+1], 32'hC0);
        end
        chk("flush_no_res", n_res - base_res, 0);
`ifdef MEM_REQ_QUEUE_STATS_EN
        chk("flush_killed", stat_killed, 2);
`endif

        // Flush while a load is on the data port.
        set_enq(1, 0, {1'b0, LEN_W}, 32'h300, 0, 4'd7);
        tick();
        enq_valid = 0;
        wait_busy();
        rob_clear = 1;
        tick();
        rob_clear = 0;
        repeat (3) begin
            tick();
            chk("kill_busy_dv", data_valid, 1);
            chk("kill_busy_addr", data_addr, 32'h300);
        end
        data_ready = 1; data_result = 32'h77;
        tick();
        data_ready = 0;
        chk("kill_busy_nores", res_valid, 0);
        tick();

        // Stall with rdy_in low; the data_ready pulse during the stall is ignored.
        set_enq(1, 0, {1'b0, LEN_W}, 32'h400, 0, 4'd5);
        tick();
        enq_valid = 0;
        wait_busy();
        rdy_in = 0;
        tick();
        data_ready = 1; data_result = 32'hBAD;
        tick();
        data_ready = 0;
        tick();
        chk("stall_dv", data_valid, 1);
        chk("stall_res", res_valid, 0);
        rdy_in = 1;
        tick();
        chk("stall_still_busy", data_valid, 1);
        data_ready = 1; data_result = 32'h12345678;
        tick();
        data_ready = 0;
        chk("stall_res_late", res_valid, 1);
        chk("stall_res_val", res_value, 32'h12345678);
        chk("stall_res_tag", res_tag, 4'd5);
        drain();

        // Random traffic with occasional flushes.
        for (int r = 0; r < 3000; r++) begin
            rdy_in = $urandom_range(0, 9) != 0;
            enq_rand($urandom_range(0, 2) == 0);
            data_ready = $urandom_range(0, 3) == 0;
            data_result = $urandom;
            if (r % 150 == 149) begin
                rdy_in = 1;
                rob_clear = 1;
            end
            tick();
            if (rob_clear) begin
                rob_clear = 0;
                drain();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_req_queue.md
# mem_req_queue

In-order load/store request queue that initiates accesses on the memory interface's data port (data_valid/data_wr/data_len/data_addr/data_value in, data_ready/data_result back). Accepts committed stores and speculative loads from the load/store logic, issues them one at a time, and returns load results tagged with their ROB index. It honours rob_clear by discarding speculative loads while still completing every store already accepted.

## Interface
- DEPTH_LOG, 3, log2 of queue depth (DEPTH = 8 entries)
- TAG_W, 4, ROB tag width
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  global enable; low freezes all state
- rob_clear  input  1  pipeline flush
- enq_valid  input  1  enqueue request, sampled on clk_in rising edge
- enq_wr  input  1  1 = store (already committed), 0 = load
- enq_len  input  3  [2] 1 = unsigned, [1:0] 00 byte / 01 half / 10 word
- enq_addr  input  32  byte address
- enq_value  input  32  store data
- enq_tag  input  TAG_W  ROB tag of load
- enq_full  output  1  queue holds DEPTH entries; registered
- data_valid / data_wr / data_len / data_addr / data_value  output  1/1/3/32/32  request to memory interface; registered
- data_ready  input  1  one-cycle completion pulse
- data_result  input  32  load data, already extended
- res_valid  output  1  one-cycle load-result pulse
- res_tag  output  TAG_W  tag of returned load
- res_value  output  32  load result
- stat_loads, stat_stores, stat_killed, stat_wait  output  32 each  statistics (see Configuration)

## Operation
- Circular buffer, head/tail pointers wrap mod DEPTH, count is DEPTH_LOG+1 bits; each entry holds {wr, len, addr, value, tag, killed}.
- Issue FSM has two states.
  - IDLE: if the head entry is killed, pop it (one per cycle, no request). Else if count>0, load the head into the data_* registers and set data_valid -> BUSY.
  - BUSY: hold data_* stable. On data_ready, clear data_valid and pop the head. For a live load, pulse res_valid with res_tag/res_value = entry tag/data_result. Then -> IDLE.
- When data_valid is low, drive data_wr=0, data_addr=0, data_value=0, data_len=3'b111.
- Enqueue happens when enq_valid && !enq_full, written at tail. An enqueue while full is dropped with no state change.
- enq_full is computed from registered count only. No same-cycle pass-through when a pop and an enqueue coincide.
- rob_clear edge:
  - Set killed on every queued load.
  - A load presented on enq in the same cycle is not written.
  - Stores are untouched.
  - An in-flight load stays BUSY until data_ready; its res_valid is suppressed.
  - An in-flight store completes normally.
- A load whose data_ready arrives in the same cycle as rob_clear is suppressed.

## Timing
- Reset: all outputs 0 except data_len=3'b111; queue empty; FSM IDLE. Reset takes effect immediately, including mid-transaction.
- Enqueue into an idle empty queue in cycle 0: entry written at edge 0→1, data_valid high from cycle 2.
- data_ready in cycle k: data_valid low and res_valid high in cycle k+1. The next request's data_valid is high no earlier than cycle k+2.
- Killed-entry skip costs 1 cycle per entry.
- rdy_in low: no enqueue, no pop, no FSM transition, counters frozen, outputs held; data_ready ignored.

## Configuration
- MEM_REQ_QUEUE_STATS_EN defined: four 32-bit wrapping counters, cleared by reset:
  - stat_loads: live loads completed
  - stat_stores: stores completed
  - stat_killed: loads discarded, whether killed in queue, dropped at enq, or suppressed in flight
  - stat_wait: BUSY cycles with rdy_in high
- Undefined: stat_* ports exist but are tied to 0; no counter logic.

## Structure
- Shared package: length-encoding constants (LEN_B, LEN_H, LEN_W, LEN_UNSIGNED_BIT), idle data_len value 3'b111, queue entry typedef.
- Sub-module mem_req_fifo: storage, pointers, count, full flag, broadside kill-loads operation. The issue FSM and stats live in mem_req_queue.

## Test plan
- Word load at addr 0x100, tag 3, enqueued cycle 0 -> data_valid high cycle 2 with data_len 3'b010; data_ready + 0xDEADBEEF in cycle 5 -> res_valid cycle 6, tag 3, value 0xDEADBEEF, data_valid low cycle 6.
- 8 enqueues with memory stalled -> enq_full high; 9th enqueue ignored; after first data_ready, enq_full low one cycle later; all 8 complete in order.
- Queue store A, load B, store C, load D; rob_clear while A is in flight -> data port sees A then C only, no res_valid, count returns to 0; stat_killed=2 with macro on.
- rob_clear while a load is BUSY -> data_valid and fields stay stable until data_ready; no res_valid pulse.
- rdy_in low 3 cycles while BUSY with data_ready pulsed during the pause -> outputs frozen, pulse ignored, completion only on a later data_ready.
- rst_in asserted mid-transaction -> data_valid 0 and data_len 3'b111 before the next edge; queue empty afterwards.
